// File: rtl/lsu_master_pkg.sv
// Shared load/store op and FSM state encodings, used by decode, DM and the LSU.
package lsu_master_pkg;

  typedef enum logic [3:0] {
    OpLb  = 4'b0000,
    OpLh  = 4'b0001,
    OpLw  = 4'b0010,
    OpLbu = 4'b0100,
    OpLhu = 4'b0101,
    OpSb  = 4'b1000,
    OpSh  = 4'b1001,
    OpSw  = 4'b1010
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBus  = 2'b01,
    StResp = 2'b10
  } state_e;

  function automatic logic op_is_store(logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic op_misaligned(logic [3:0] op, logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (op)
      OpLw, OpSw:        mis = (addr_lo != 2'b00);
      OpLh, OpLhu, OpSh: mis = addr_lo[0];
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store data replication and load extraction.
module lsu_align
  import lsu_master_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = bus_rdata >> {addr_lo, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  end

  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0;
    load_data = 32'h0;
    case (op)
      OpLb: begin
        be        = 4'b0001 << addr_lo;
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end
      OpLbu: begin
        be        = 4'b0001 << addr_lo;
        load_data = {24'h0, byte_sel};
      end
      OpLh: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data = {{16{half_sel[15]}}, half_sel};
      end
      OpLhu: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data = {16'h0, half_sel};
      end
      OpLw: begin
        be        = 4'b1111;
        load_data = bus_rdata;
      end
      OpSb: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      OpSh: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      OpSw: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// M-stage load/store unit: one bus access per request, with alignment and timeout errors.
module lsu_master
  import lsu_master_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [3:0]    al_be;
  logic [31:0]   al_wdata;
  logic [31:0]   al_load;
  logic          in_bus;

  lsu_align u_align (
    .op        (op_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .bus_rdata (bus_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .load_data (al_load)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          if (op_misaligned(op, addr[1:0])) begin
            state_d = StResp;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end else begin
            state_d = StBus;
          end
        end
      end
      StBus: begin
        // An ack on the final wait cycle still wins over the timeout.
        if (bus_ack) begin
          state_d = StResp;
          rdata_d = op_is_store(op_q) ? 32'h0 : al_load;
          err_d   = 1'b0;
        end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
          state_d = StResp;
          rdata_d = 32'h0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs are gated by state so they read as zero whenever no access is live.
  always_comb begin
    in_bus     = (state_q == StBus);
    req_ready  = (state_q == StIdle);
    stall      = ((state_q == StIdle) && req_valid) || in_bus;
    resp_valid = (state_q == StResp);
    rdata      = rdata_q;
    err        = err_q;
    bus_req    = in_bus;
    bus_we     = in_bus && op_is_store(op_q);
    bus_addr   = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
    bus_be     = in_bus ? al_be : 4'b0000;
    bus_wdata  = in_bus ? al_wdata : 32'h0;
  end

endmodule

// File: tb/tb_lsu_master.sv
// Scoreboard bench for lsu_master with a short wait limit to reach the timeout quickly.
module tb_lsu_master;
  import lsu_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  op = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  lsu_master #(.MAX_WAIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .err        (err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_resp = 0;
  logic [32:0] exp_q[$];

  // Observations gathered by run_access for the scenario tasks to judge.
  int          obs_bus_cycles;
  logic        obs_unstable, obs_stall_bus, obs_stall_req, obs_ready_req;
  logic        obs_resp, obs_stall_resp, obs_req_resp, obs_resp_after, obs_ready_after;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata;
  logic        obs_we;

  // Response monitor: every resp_valid pulse must match the oldest expected result.
  initial begin
    logic        prev;
    logic [32:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && resp_valid) begin
        n_resp++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL resp_unexpected: got rdata=%h err=%b, required no response", rdata, err);
        end else begin
          e = exp_q.pop_front();
          if ({rdata, err} !== e) begin
            n_err++;
            $display("FAIL resp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                     rdata, err, e[32:1], e[0]);
          end
        end
        if (prev) begin
          n_err++;
          $display("FAIL resp_one_cycle: got resp_valid held 2 cycles, required 1");
        end
      end
      prev = resp_valid && !reset;
    end
  end

  task automatic run_access(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int ack_at);
    obs_bus_cycles = 0;
    obs_unstable   = 1'b0;
    obs_stall_bus  = 1'b1;
    req_valid = 1'b1;
    op        = o;
    addr      = a;
    wdata     = wd;
    #1;
    obs_stall_req = stall;
    obs_ready_req = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (!bus_req) break;
      if (cyc == 1) begin
        obs_be    = bus_be;
        obs_addr  = bus_addr;
        obs_wdata = bus_wdata;
        obs_we    = bus_we;
      end else if (bus_be !== obs_be || bus_addr !== obs_addr || bus_wdata !== obs_wdata ||
                   bus_we !== obs_we) begin
        obs_unstable = 1'b1;
      end
      obs_bus_cycles++;
      obs_stall_bus = obs_stall_bus & stall;
      if (cyc == ack_at) begin
        bus_ack   = 1'b1;
        bus_rdata = rd;
      end
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = $urandom();
    end
    obs_resp       = resp_valid;
    obs_stall_resp = stall;
    obs_req_resp   = bus_req;
    @(negedge clk);
    obs_resp_after  = resp_valid;
    obs_ready_after = req_ready;
  endtask

  function automatic logic [31:0] model_load(logic [3:0] o, logic [31:0] a, logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*a[1:0] +: 8];
    h = rd[16*a[1] +: 16];
    case (o)
      OpLw:    return rd;
      OpLb:    return 32'($signed(b));
      OpLbu:   return {24'h0, b};
      OpLh:    return 32'($signed(h));
      OpLhu:   return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_reset();
    n_cmp++;
    if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== 70'h0) begin
      n_err++;
      $display("FAIL reset_bus: got req=%b we=%b be=%b addr=%h wdata=%h, required all 0",
               bus_req, bus_we, bus_be, bus_addr, bus_wdata);
    end
    n_cmp++;
    if ({resp_valid, err, rdata, stall, req_ready} !== {35'h0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_resp: got resp_valid=%b err=%b rdata=%h stall=%b ready=%b, required 0/0/0/0/1",
               resp_valid, err, rdata, stall, req_ready);
    end
  endtask

  task automatic test_store_byte();
    exp_q.push_back({32'h0, 1'b0});
    run_access(OpSb, 32'h0000_0013, 32'h0000_00AB, 32'hDEAD_BEEF, 2);
    n_cmp++;
    if (obs_bus_cycles !== 2) begin
      n_err++; $display("FAIL sb_bus_cycles: got %0d, required 2", obs_bus_cycles);
    end
    n_cmp++;
    if ({obs_be, obs_addr, obs_wdata, obs_we} !== {4'b1000, 32'h10, 32'hABAB_ABAB, 1'b1}) begin
      n_err++;
      $display("FAIL sb_bus: got be=%b addr=%h wdata=%h we=%b, required 1000/00000010/ababab ab/1",
               obs_be, obs_addr, obs_wdata, obs_we);
    end
    n_cmp++;
    if (obs_unstable !== 1'b0 || obs_stall_bus !== 1'b1 || obs_stall_req !== 1'b1) begin
      n_err++;
      $display("FAIL sb_hold: got unstable=%b stall_bus=%b stall_req=%b, required 0/1/1",
               obs_unstable, obs_stall_bus, obs_stall_req);
    end
    n_cmp++;
    if ({obs_resp, obs_stall_resp, obs_resp_after, obs_ready_after} !== 4'b1001) begin
      n_err++;
      $display("FAIL sb_resp: got resp=%b stall=%b resp_after=%b ready_after=%b, required 1/0/0/1",
               obs_resp, obs_stall_resp, obs_resp_after, obs_ready_after);
    end
  endtask

  task automatic test_load_half();
    exp_q.push_back({32'hFFFF_8001, 1'b0});
    run_access(OpLh, 32'h6, 32'h0, 32'h8001_7FFF, 1);
    n_cmp++;
    if ({obs_be, obs_we, obs_addr} !== {4'b1100, 1'b0, 32'h4}) begin
      n_err++;
      $display("FAIL lh_bus: got be=%b we=%b addr=%h, required 1100/0/00000004",
               obs_be, obs_we, obs_addr);
    end
    exp_q.push_back({32'h0000_8001, 1'b0});
    run_access(OpLhu, 32'h6, 32'h0, 32'h8001_7FFF, 1);
    n_cmp++;
    if (obs_bus_cycles !== 1 || obs_resp !== 1'b1) begin
      n_err++;
      $display("FAIL lhu_flow: got cycles=%0d resp=%b, required 1/1", obs_bus_cycles, obs_resp);
    end
  endtask

  task automatic test_misaligned();
    exp_q.push_back({32'h0, 1'b1});
    run_access(OpLw, 32'h5, 32'h0, 32'h1234_5678, 1);
    n_cmp++;
    if (obs_bus_cycles !== 0 || obs_resp !== 1'b1 || obs_resp_after !== 1'b0) begin
      n_err++;
      $display("FAIL lw_misaligned: got bus_cycles=%0d resp=%b resp_after=%b, required 0/1/0",
               obs_bus_cycles, obs_resp, obs_resp_after);
    end
    exp_q.push_back({32'h0, 1'b1});
    run_access(OpSh, 32'h3, 32'h0, 32'h0, 1);
    n_cmp++;
    if (obs_bus_cycles !== 0) begin
      n_err++; $display("FAIL sh_misaligned: got bus_cycles=%0d, required 0", obs_bus_cycles);
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back({32'h0, 1'b1});
    run_access(OpSw, 32'h8, 32'h1357_9BDF, 32'h0, 0);
    n_cmp++;
    if (obs_bus_cycles !== 4 || obs_req_resp !== 1'b0 || obs_stall_resp !== 1'b0) begin
      n_err++;
      $display("FAIL sw_timeout: got bus_cycles=%0d req_in_resp=%b stall_in_resp=%b, required 4/0/0",
               obs_bus_cycles, obs_req_resp, obs_stall_resp);
    end
  endtask

  task automatic test_ack_at_limit();
    exp_q.push_back({32'hFFFF_FF80, 1'b0});
    run_access(OpLb, 32'h1, 32'h0, 32'h0000_8000, 4);
    n_cmp++;
    if (obs_bus_cycles !== 4 || obs_be !== 4'b0010) begin
      n_err++;
      $display("FAIL lb_limit: got bus_cycles=%0d be=%b, required 4/0010", obs_bus_cycles, obs_be);
    end
  endtask

  task automatic test_ack_ignored();
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({resp_valid, bus_req, req_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL ack_idle: got resp_valid=%b bus_req=%b ready=%b, required 0/0/1",
               resp_valid, bus_req, req_ready);
    end
  endtask

  task automatic test_reset_mid_bus();
    int resp_before;
    logic bad;
    resp_before = n_resp;
    req_valid = 1'b1;
    op        = OpLw;
    addr      = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (bus_req !== 1'b1) begin
      n_err++; $display("FAIL rst_pre: got bus_req=%b, required 1", bus_req);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus_req, bus_be, bus_addr} !== 37'h0) begin
      n_err++;
      $display("FAIL rst_async: got bus_req=%b be=%b addr=%h, required all 0",
               bus_req, bus_be, bus_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_req !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0 || n_resp !== resp_before) begin
      n_err++;
      $display("FAIL rst_after: got bus_activity=%b responses=%0d, required 0/%0d",
               bad, n_resp - resp_before, 0);
    end
  endtask

  task automatic test_random();
    logic [3:0] ops [8];
    logic [3:0] o, exp_be;
    logic [31:0] a, wd, rd, exp_wd;
    int ack_at;
    ops = '{OpLb, OpLbu, OpLh, OpLhu, OpLw, OpSb, OpSh, OpSw};
    for (int i = 0; i < 12; i++) begin
      o      = ops[$urandom_range(0, 7)];
      a      = $urandom();
      wd     = $urandom();
      rd     = $urandom();
      ack_at = $urandom_range(1, 3);
      if (o == OpLw || o == OpSw) a[1:0] = 2'b00;
      if (o == OpLh || o == OpLhu || o == OpSh) a[0] = 1'b0;
      if (o == OpLw || o == OpSw) exp_be = 4'b1111;
      else if (o == OpLh || o == OpLhu || o == OpSh) exp_be = a[1] ? 4'b1100 : 4'b0011;
      else exp_be = 4'b0001 << a[1:0];
      if (o == OpSb) exp_wd = {4{wd[7:0]}};
      else if (o == OpSh) exp_wd = {2{wd[15:0]}};
      else if (o == OpSw) exp_wd = wd;
      else exp_wd = 32'h0;
      exp_q.push_back({model_load(o, a, rd), 1'b0});
      run_access(o, a, wd, rd, ack_at);
      n_cmp++;
      if (obs_be !== exp_be || obs_addr !== {a[31:2], 2'b00} || obs_we !== o[3] ||
          obs_bus_cycles !== ack_at) begin
        n_err++;
        $display("FAIL rand_bus op=%h: got be=%b addr=%h we=%b cycles=%0d, required %b/%h/%b/%0d",
                 o, obs_be, obs_addr, obs_we, obs_bus_cycles, exp_be, {a[31:2], 2'b00}, o[3],
                 ack_at);
      end
      if (o[3]) begin
        n_cmp++;
        if (obs_wdata !== exp_wd) begin
          n_err++;
          $display("FAIL rand_wdata op=%h: got %h, required %h", o, obs_wdata, exp_wd);
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_store_byte();
    test_load_half();
    test_misaligned();
    test_timeout();
    test_ack_at_limit();
    test_ack_ignored();
    test_reset_mid_bus();
    test_random();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d responses missing, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
